gate_stim_checker: RTL and testbench
====================================

GATE_STIM_CHECKER -- requirements
Module: gate_stim_checker

Interface
REQ-001 Parameter HOLD_CYCLES, default 2, number of settle cycles each vector is held before sampling (legal 1..255).
REQ-002 Parameter ERR_W, default 4, width of err_count (legal 2..16).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  launch request, sampled in IDLE (and at end of pass in loop mode).
REQ-006 A  output  1  stimulus input A to gates under test.
REQ-007 B  output  1  stimulus input B to gates under test.
REQ-008 Y_and, Y_or, Y_not, Y_xor  input  1 each  gate-under-test responses.
REQ-009 busy  output  1  high in DRIVE and SAMPLE.
REQ-010 done  output  1  high in DONE.
REQ-011 pass  output  1  valid when done; high iff err_count == 0.
REQ-012 err_count  output  ERR_W  saturating count of mismatching gate outputs.
REQ-013 fail_mask  output  4  sticky per-gate fail flags: [0]=AND, [1]=OR, [2]=NOT, [3]=XOR.
REQ-014 first_fail_vec  output  2  index of first vector with any mismatch; 0 if none.

Function
REQ-015 FSM states: IDLE, DRIVE, SAMPLE, DONE.
REQ-016 IDLE with start=1 -> DRIVE; err_count, fail_mask and first_fail_vec clear; vector index = 0.
REQ-017 Vector order 0..3 = {A,B} 00, 01, 10, 11; A,B registered and driven from vector index in DRIVE and SAMPLE; A=B=0 in IDLE and DONE.
REQ-018 DRIVE lasts exactly HOLD_CYCLES cycles, then SAMPLE for exactly 1 cycle.
REQ-019 At the SAMPLE edge, compare inputs to expected values: AND=A&B, OR=A|B, NOT=~A, XOR=A^B.
REQ-020 err_count += number of mismatching gates (0..4) at that edge, saturating at 2^ERR_W-1.
REQ-021 Each mismatching gate sets its fail_mask bit; bits are never cleared except by reset or a new launch.
REQ-022 first_fail_vec captures the vector index on the first sample with any mismatch; later mismatches do not change it.
REQ-023 SAMPLE with index<3 -> DRIVE with index+1; SAMPLE with index 3 -> DONE.
REQ-024 done rises exactly 4*(HOLD_CYCLES+1) cycles after the start edge (12 with defaults).
REQ-025 DONE holds done, pass and results until start=1, which relaunches per REQ-016.
REQ-026 start is ignored while busy.

Reset
REQ-027 rst=1 forces IDLE immediately, independent of clk.
REQ-028 While reset is asserted: A=B=0, busy=done=pass=0, err_count=0, fail_mask=0, first_fail_vec=0, index=0, hold counter=0.
REQ-029 Reset mid-run abandons the sequence; no output retains a partial result.

Configuration
REQ-030 Macro GATE_CHECK_LOOP_EN, when defined: at the SAMPLE edge of vector 3, start=1 -> DRIVE with index 0, done pulsing for that one cycle (DRIVE). Results accumulate and are not cleared. start=0 at that edge -> DONE as normal.
REQ-031 When GATE_CHECK_LOOP_EN is undefined: single pass only; start is ignored outside IDLE/DONE.

Verification
REQ-032 Ideal gates, defaults, 1-cycle start pulse -> A,B step 00,01,10,11 every 3 cycles; done at cycle 12; pass=1; err_count=0; fail_mask=0000.
REQ-033 Y_and stuck at 0 -> err_count=1; fail_mask=0001; first_fail_vec=3; pass=0.
REQ-034 Y_xor inverted, Y_not stuck at 1 -> err_count=6 (4 XOR + 2 NOT); fail_mask=1100; first_fail_vec=0.
REQ-035 All four outputs inverted, ERR_W=4 -> 16 mismatches saturate; err_count=15; fail_mask=1111.
REQ-036 rst asserted mid-run during vector 2 DRIVE -> same cycle A=B=0, busy=0, all results 0; after release, a fresh start completes in 12 cycles.
REQ-037 GATE_CHECK_LOOP_EN defined, start held high, Y_and stuck at 0 for 2 passes, then start=0 -> err_count=2; done pulses once between passes, then holds.

Source files
------------

// File: rtl/gate_stim_if.sv
// Stimulus/response bundle between the gate checker and the gates under test.
//   start            - launch request into the checker
//   A, B             - stimulus driven by the checker
//   Y_and .. Y_xor   - gate responses returned to the checker
//   busy, done, pass - checker status
//   err_count        - saturating mismatch count (ERR_W bits)
//   fail_mask        - sticky per-gate fail flags {XOR, NOT, OR, AND}
//   first_fail_vec   - index of the first vector that showed a mismatch
// master: the checker. slave: the environment (gates under test plus launcher).
interface gate_stim_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             A;
    logic             B;
    logic             Y_and;
    logic             Y_or;
    logic             Y_not;
    logic             Y_xor;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       fail_mask;
    logic [1:0]       first_fail_vec;

    modport master (
        input  start, Y_and, Y_or, Y_not, Y_xor,
        output A, B, busy, done, pass, err_count, fail_mask, first_fail_vec
    );

    modport slave (
        output start, Y_and, Y_or, Y_not, Y_xor,
        input  A, B, busy, done, pass, err_count, fail_mask, first_fail_vec
    );
endinterface

// File: rtl/gate_stim_checker.sv
// Exhaustive two-input stimulus generator and response checker for AND/OR/NOT/XOR
// gates. Vectors {A,B} = 00,01,10,11 are each held HOLD_CYCLES cycles (DRIVE) and
// then checked for one cycle (SAMPLE). Mismatches accumulate into a saturating
// counter, a sticky per-gate mask and the index of the first failing vector.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - gate_stim_if.master (start in, stimulus out, responses in, results out)
// Parameters: HOLD_CYCLES (1..255), ERR_W (2..16), must match the interface ERR_W.
// Optional feature macro GATE_CHECK_LOOP_EN: with start held high at the end of a
// pass, the sequence restarts at vector 0 without clearing results and done pulses
// for one cycle between passes.
module gate_stim_checker #(
    parameter int HOLD_CYCLES = 2,
    parameter int ERR_W       = 4
) (
    input logic        clk,
    input logic        rst,
    gate_stim_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam int               SUM_W     = ERR_W + 1;
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

`ifdef GATE_CHECK_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_t           state_r;
    logic [1:0]       idx_r;
    logic [7:0]       hold_r;
    logic             a_r;
    logic             b_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [ERR_W-1:0] err_r;
    logic [3:0]       mask_r;
    logic [1:0]       ffv_r;

    logic [3:0]       mism_s;
    logic [2:0]       mism_cnt_s;
    logic [SUM_W-1:0] sum_s;
    logic [ERR_W-1:0] err_next_s;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Per-gate mismatch against the ideal response and the saturated error total.
    // SUM_W = ERR_W+1 is wide enough because 2^ERR_W-1+4 fits for ERR_W >= 2.
    always_comb begin
        mism_s     = {bus.Y_xor ^ (a_r ^ b_r),
                      bus.Y_not ^ (~a_r),
                      bus.Y_or  ^ (a_r | b_r),
                      bus.Y_and ^ (a_r & b_r)};
        mism_cnt_s = popcount4(mism_s);
        sum_s      = {1'b0, err_r} + SUM_W'(mism_cnt_s);
        if (sum_s > {1'b0, ERR_MAX}) begin
            err_next_s = ERR_MAX;
        end else begin
            err_next_s = sum_s[ERR_W-1:0];
        end
    end

    // Sequencer: vector stepping, hold timing, result accumulation, status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= 2'd0;
            hold_r  <= 8'd0;
            a_r     <= 1'b0;
            b_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= '0;
            mask_r  <= 4'd0;
            ffv_r   <= 2'd0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_r <= DRIVE;
                        idx_r   <= 2'd0;
                        hold_r  <= 8'd0;
                        a_r     <= 1'b0;
                        b_r     <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                        err_r   <= '0;
                        mask_r  <= 4'd0;
                        ffv_r   <= 2'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                DRIVE: begin
                    // done/pass only survive one cycle here after a looped pass
                    done_r <= 1'b0;
                    pass_r <= 1'b0;
                    if (hold_r == HOLD_LAST) begin
                        state_r <= SAMPLE;
                        hold_r  <= 8'd0;
                    end else begin
                        hold_r  <= hold_r + 8'd1;
                    end
                end
                SAMPLE: begin
                    err_r  <= err_next_s;
                    mask_r <= mask_r | mism_s;
                    // an all-zero mask means no earlier vector has failed
                    if ((mism_s != 4'd0) && (mask_r == 4'd0)) begin
                        ffv_r <= idx_r;
                    end else begin
                        ffv_r <= ffv_r;
                    end
                    if (idx_r != 2'd3) begin
                        state_r      <= DRIVE;
                        idx_r        <= idx_r + 2'd1;
                        {a_r, b_r}   <= idx_r + 2'd1;
                    end else if (LOOP_EN && bus.start) begin
                        state_r <= DRIVE;
                        idx_r   <= 2'd0;
                        a_r     <= 1'b0;
                        b_r     <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (err_next_s == '0);
                    end else begin
                        state_r <= DONE;
                        a_r     <= 1'b0;
                        b_r     <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (err_next_s == '0);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    a_r     <= 1'b0;
                    b_r     <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A              = a_r;
    assign bus.B              = b_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.pass           = pass_r;
    assign bus.err_count      = err_r;
    assign bus.fail_mask      = mask_r;
    assign bus.first_fail_vec = ffv_r;

endmodule

// File: tb/tb_gate_stim_checker.sv
module tb_gate_stim_checker;

    localparam int HOLD = 2;
    localparam int EW   = 4;
    localparam int RUN  = 4 * (HOLD + 1);

    typedef struct {
        logic [EW-1:0] err;
        logic [3:0]    mask;
        logic [1:0]    ffv;
        logic          pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   fault_mode = 0;
    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    gate_stim_if #(.ERR_W(EW)) bus ();

    gate_stim_checker #(.HOLD_CYCLES(HOLD), .ERR_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Gates under test, with injectable faults. Returns {xor, not, or, and}.
    function automatic logic [3:0] gate_resp(input int mode, input logic a, input logic b);
        logic [3:0] r;
        r = {a ^ b, ~a, a | b, a & b};
        case (mode)
            1: r[0] = 1'b0;                          // AND stuck at 0
            2: begin r[3] = ~r[3]; r[2] = 1'b1; end  // XOR inverted, NOT stuck at 1
            3: r = ~r;                               // everything inverted
            default: ;
        endcase
        return r;
    endfunction

    always_comb begin
        {bus.Y_xor, bus.Y_not, bus.Y_or, bus.Y_and} = gate_resp(fault_mode, bus.A, bus.B);
    end

    // Reference: expected results after a number of passes with a given fault.
    function automatic exp_t model_run(input int mode, input int passes);
        exp_t       e;
        int         sum;
        logic [1:0] v;
        logic [3:0] ideal;
        logic [3:0] m;
        bit         anyf;
        sum = 0; anyf = 1'b0;
        e.mask = 4'd0; e.ffv = 2'd0;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < 4; i++) begin
                v     = 2'(i);
                ideal = {v[1] ^ v[0], ~v[1], v[1] | v[0], v[1] & v[0]};
                m     = gate_resp(mode, v[1], v[0]) ^ ideal;
                for (int g = 0; g < 4; g++) if (m[g]) sum++;
                if (sum > 15) sum = 15;
                e.mask = e.mask | m;
                if ((m != 4'd0) && !anyf) begin e.ffv = v; anyf = 1'b1; end
            end
        end
        e.err  = 4'(sum);
        e.pass = (sum == 0);
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_results(input exp_t e, input string pfx);
        check_val({pfx, "_err"},  32'(bus.err_count),      32'(e.err));
        check_val({pfx, "_mask"}, 32'(bus.fail_mask),      32'(e.mask));
        check_val({pfx, "_ffv"},  32'(bus.first_fail_vec), 32'(e.ffv));
        check_val({pfx, "_pass"}, 32'(bus.pass),           32'(e.pass));
    endtask

    // One single pass: checks stepping every cycle, done latency and final results.
    task automatic run_pass(input int mode, input bit poke_start);
        exp_t e;
        int   cyc;
        int   vec;
        fault_mode = mode;
        sb_q.push_back(model_run(mode, 1));
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 0; k < RUN; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            vec = k / (HOLD + 1);
            check_val("vec_A", 32'(bus.A), 32'((vec >> 1) & 1));
            check_val("vec_B", 32'(bus.B), 32'(vec & 1));
            check_val("busy",  32'(bus.busy), 32'd1);
            check_val("done_early", 32'(bus.done), 32'd0);
            bus.start = (poke_start && (k == 4 || k == 5)) ? 1'b1 : 1'b0;
        end
        cyc = RUN;
        @(posedge clk);
        #1;
        while (!bus.done && cyc < RUN + 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val("latency", 32'(cyc), 32'(RUN));
        e = sb_q.pop_front();
        check_results(e, "res");
        check_val("idle_busy", 32'(bus.busy), 32'd0);
        check_val("idle_AB",   32'({bus.A, bus.B}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("done_hold", 32'(bus.done), 32'd1);
        check_val("err_hold",  32'(bus.err_count), 32'(e.err));
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_AB",   32'({bus.A, bus.B}), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_pass", 32'(bus.pass), 32'd0);
        check_val("rst_err",  32'(bus.err_count), 32'd0);
        check_val("rst_mask", 32'(bus.fail_mask), 32'd0);
        check_val("rst_ffv",  32'(bus.first_fail_vec), 32'd0);
        @(negedge clk) rst = 1'b0;

        run_pass(0, 1'b1);   // ideal gates, start poked while busy
        run_pass(1, 1'b0);   // AND stuck 0
        run_pass(2, 1'b0);   // XOR inverted + NOT stuck 1
        run_pass(3, 1'b0);   // all inverted, saturates

        // Reset during vector 2 DRIVE with errors already accumulated.
        fault_mode = 3;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2 * (HOLD + 1)) @(posedge clk);
        #1;
        check_val("mid_A",   32'(bus.A), 32'd1);
        check_val("mid_err", 32'(bus.err_count), 32'd8);
        rst = 1'b1;
        #1;
        check_val("arst_AB",   32'({bus.A, bus.B}), 32'd0);
        check_val("arst_busy", 32'(bus.busy), 32'd0);
        check_val("arst_err",  32'(bus.err_count), 32'd0);
        check_val("arst_mask", 32'(bus.fail_mask), 32'd0);
        check_val("arst_done", 32'({bus.done, bus.pass}), 32'd0);
        @(negedge clk) rst = 1'b0;
        run_pass(0, 1'b0);

`ifdef GATE_CHECK_LOOP_EN
        begin
            exp_t e;
            int   cyc;
            fault_mode = 1;
            sb_q.push_back(model_run(1, 2));
            @(negedge clk) bus.start = 1'b1;
            @(posedge clk);
            #1;
            cyc = 0;
            while (cyc < 3 * RUN) begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc == RUN) begin
                    check_val("loop_pulse",      32'(bus.done), 32'd1);
                    check_val("loop_pulse_busy", 32'(bus.busy), 32'd1);
                    check_val("loop_mid_err",    32'(bus.err_count), 32'd1);
                end
                if (cyc == RUN + 1) begin
                    check_val("loop_pulse_end", 32'(bus.done), 32'd0);
                    bus.start = 1'b0;
                end
                if (bus.done && cyc > RUN) break;
            end
            check_val("loop_latency", 32'(cyc), 32'(2 * RUN));
            e = sb_q.pop_front();
            check_results(e, "loop");
            repeat (2) @(posedge clk);
            #1;
            check_val("loop_hold", 32'(bus.done), 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
